// File: rtl/gfx_arb_pkg.sv
// Shared types and slot constants for the VRAM time-slot arbiter.
// No ports; imported by vram_slot_decode and vram_slot_arbiter.
package gfx_arb_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_CPU  = 3'd1,
        SRC_PF   = 3'd2,
        SRC_MO   = 3'd3,
        SRC_AL   = 3'd4
    } slot_src_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } cpu_state_t;

    localparam logic [2:0] PF_SLOT  = 3'd0;
    localparam logic [2:0] MO_SLOT0 = 3'd2;
    localparam logic [2:0] AL_SLOT  = 3'd4;
    localparam logic [2:0] MO_SLOT1 = 3'd6;

    function automatic logic is_video(slot_src_t src);
        return (src == SRC_PF) || (src == SRC_MO) || (src == SRC_AL);
    endfunction

endpackage

// File: rtl/vram_slot_decode.sv
// Slot table: maps the current slot number to the owner of the VRAM port.
// Purely combinational.
//   slot_cnt  in   position within the 8-slot line cycle
//   VBLANK_b  in   low during vertical blank (CPU owns every slot)
//   pf_en/mo_en/al_en in  engine wants its slots this line
//   owner     out  slot_src_t owner of this slot (SRC_CPU or a video engine)
module vram_slot_decode
    import gfx_arb_pkg::*;
(
    input  logic [2:0] slot_cnt,
    input  logic       VBLANK_b,
    input  logic       pf_en,
    input  logic       mo_en,
    input  logic       al_en,
    output logic [2:0] owner
);

    slot_src_t owner_e;

    always_comb begin
        owner_e = SRC_CPU;
        if (VBLANK_b) begin
            case (slot_cnt)
                PF_SLOT:            if (pf_en) owner_e = SRC_PF;
                MO_SLOT0, MO_SLOT1: if (mo_en) owner_e = SRC_MO;
                AL_SLOT:            if (al_en) owner_e = SRC_AL;
                default:            owner_e = SRC_CPU;
            endcase
        end
    end

    assign owner = owner_e;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Time-slot arbiter sharing the single VRAM port between the 68k CPU and the
// playfield, motion-object and alphanumerics fetch engines.
//   reset, CLK_1H            async active-high reset, clock
//   line_start, VBLANK_b     line alignment pulse, vertical blank (low)
//   pf/mo/al_en, *_addr      engine slot requests and fetch addresses
//   pf/mo/al_valid           fetch data present on vram_rdata this cycle
//   cpu_req/we/addr/wdata    CPU bus request (level, held until ack)
//   cpu_rdata, cpu_ack       CPU read data and acknowledge
//   vram_addr/we/wdata/src   VRAM port controls and owner of this cycle
//   vram_rdata               VRAM read data, one cycle after address
//   stat_clr, wait_max       longest CPU wait statistic and its clear
//
// CPU access FSM
//   state | meaning
//   IDLE  | no CPU access outstanding
//   WAIT  | request seen, waiting for a CPU-owned slot
//   ACK   | access done, cpu_ack held until cpu_req falls
module vram_slot_arbiter
    import gfx_arb_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int WAITCNT_W = 8
) (
    input  logic                 reset,
    input  logic                 CLK_1H,
    input  logic                 line_start,
    input  logic                 VBLANK_b,
    input  logic                 pf_en,
    input  logic                 mo_en,
    input  logic                 al_en,
    input  logic [ADDR_W-1:0]    pf_addr,
    input  logic [ADDR_W-1:0]    mo_addr,
    input  logic [ADDR_W-1:0]    al_addr,
    output logic                 pf_valid,
    output logic                 mo_valid,
    output logic                 al_valid,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
    output logic [DATA_W-1:0]    cpu_rdata,
    output logic                 cpu_ack,
    output logic [ADDR_W-1:0]    vram_addr,
    output logic                 vram_we,
    output logic [DATA_W-1:0]    vram_wdata,
    input  logic [DATA_W-1:0]    vram_rdata,
    output logic [2:0]           vram_src,
    input  logic                 stat_clr,
    output logic [WAITCNT_W-1:0] wait_max
);

    localparam logic [WAITCNT_W-1:0] WAIT_ONE = {{(WAITCNT_W-1){1'b0}}, 1'b1};

    logic [2:0]           slot_cnt;
    logic [2:0]           owner_raw;
    slot_src_t            owner;
    cpu_state_t           state, state_nxt;
    logic                 access;
    logic                 rd_pending;
    logic [DATA_W-1:0]    rdata_q;
    logic [WAITCNT_W-1:0] wait_cnt;

    vram_slot_decode u_decode (
        .slot_cnt (slot_cnt),
        .VBLANK_b (VBLANK_b),
        .pf_en    (pf_en),
        .mo_en    (mo_en),
        .al_en    (al_en),
        .owner    (owner_raw)
    );

    assign owner = slot_src_t'(owner_raw);

    // Gating with reset keeps the port quiet (and write-free) the moment
    // reset rises, without waiting for a clock edge.
    assign access = (state == WAIT) && cpu_req && (owner == SRC_CPU) && !reset;

    always_comb begin
        vram_src   = SRC_NONE;
        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        if (!reset) begin
            case (owner)
                SRC_PF: begin
                    vram_src  = SRC_PF;
                    vram_addr = pf_addr;
                end
                SRC_MO: begin
                    vram_src  = SRC_MO;
                    vram_addr = mo_addr;
                end
                SRC_AL: begin
                    vram_src  = SRC_AL;
                    vram_addr = al_addr;
                end
                default: begin
                    if (access) begin
                        vram_src   = SRC_CPU;
                        vram_addr  = cpu_addr;
                        vram_we    = cpu_we;
                        vram_wdata = cpu_wdata;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cpu_req) state_nxt = WAIT;
            WAIT: begin
                if (!cpu_req)    state_nxt = IDLE;
                else if (access) state_nxt = ACK;
            end
            ACK:     if (!cpu_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_1H or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            slot_cnt   <= 3'd0;
            pf_valid   <= 1'b0;
            mo_valid   <= 1'b0;
            al_valid   <= 1'b0;
            rd_pending <= 1'b0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
            wait_max   <= '0;
        end else begin
            state    <= state_nxt;
            slot_cnt <= line_start ? 3'd0 : slot_cnt + 3'd1;

            pf_valid <= (owner == SRC_PF);
            mo_valid <= (owner == SRC_MO);
            al_valid <= (owner == SRC_AL);

            rd_pending <= access && !cpu_we;
            if (rd_pending) rdata_q <= vram_rdata;

            if (state == IDLE && cpu_req)
                wait_cnt <= '0;
            else if (state == WAIT && cpu_req && !access && wait_cnt != '1)
                wait_cnt <= wait_cnt + WAIT_ONE;

            if (stat_clr)
                wait_max <= '0;
            else if (access && wait_cnt > wait_max)
                wait_max <= wait_cnt;
        end
    end

    // VRAM data for a read arrives the cycle after the access, which is
    // also the first ACK cycle; pass it straight through then and serve
    // the held copy for the rest of the ACK.
    assign cpu_rdata = rd_pending ? vram_rdata : rdata_q;
    assign cpu_ack   = (state == ACK);

endmodule

// File: tb/tb_vram_slot_arbiter.sv
module tb_vram_slot_arbiter;
    import gfx_arb_pkg::*;

    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 16;
    localparam int WAITCNT_W = 8;

    logic                 reset, CLK_1H, line_start, VBLANK_b;
    logic                 pf_en, mo_en, al_en;
    logic [ADDR_W-1:0]    pf_addr, mo_addr, al_addr;
    logic                 pf_valid, mo_valid, al_valid;
    logic                 cpu_req, cpu_we;
    logic [ADDR_W-1:0]    cpu_addr;
    logic [DATA_W-1:0]    cpu_wdata, cpu_rdata;
    logic                 cpu_ack;
    logic [ADDR_W-1:0]    vram_addr;
    logic                 vram_we;
    logic [DATA_W-1:0]    vram_wdata, vram_rdata;
    logic [2:0]           vram_src;
    logic                 stat_clr;
    logic [WAITCNT_W-1:0] wait_max;

    int n_vec = 0;
    int n_bad = 0;

    vram_slot_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAITCNT_W(WAITCNT_W)) dut (
        .reset(reset), .CLK_1H(CLK_1H), .line_start(line_start), .VBLANK_b(VBLANK_b),
        .pf_en(pf_en), .mo_en(mo_en), .al_en(al_en),
        .pf_addr(pf_addr), .mo_addr(mo_addr), .al_addr(al_addr),
        .pf_valid(pf_valid), .mo_valid(mo_valid), .al_valid(al_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata), .vram_src(vram_src),
        .stat_clr(stat_clr), .wait_max(wait_max)
    );

    initial CLK_1H = 1'b0;
    always #5 CLK_1H = ~CLK_1H;

    // Synchronous VRAM: one known word, otherwise data echoes the address.
    always @(posedge CLK_1H)
        vram_rdata <= (vram_addr == 15'h1234) ? 16'hBEEF : {1'b0, vram_addr};

    typedef struct {
        logic        ls;
        logic        vb;
        logic        en;
        logic [2:0]  src;
        logic [14:0] addr;
        logic        pfv;
        logic        mov;
        logic        alv;
    } vec_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_1H);
        #1;
    endtask

    task automatic go_slot(input int k);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        repeat (k) tick();
    endtask

    int        nwe, we_at;
    logic [14:0] we_addr;
    logic [15:0] we_data;

    initial begin
        // ls vb en src addr pfv mov alv
        vt[0]  = '{0,1,1,SRC_PF,  15'h0A00,0,0,0};
        vt[1]  = '{0,1,1,SRC_NONE,15'h0000,1,0,0};
        vt[2]  = '{0,1,1,SRC_MO,  15'h0B00,0,0,0};
        vt[3]  = '{0,1,1,SRC_NONE,15'h0000,0,1,0};
        vt[4]  = '{0,1,1,SRC_AL,  15'h0C00,0,0,0};
        vt[5]  = '{0,1,1,SRC_NONE,15'h0000,0,0,1};
        vt[6]  = '{0,1,1,SRC_MO,  15'h0B00,0,0,0};
        vt[7]  = '{0,1,1,SRC_NONE,15'h0000,0,1,0};
        for (int i = 8; i < 16; i++) vt[i] = '{0,0,1,SRC_NONE,15'h0000,0,0,0};
        vt[16] = '{1,1,1,SRC_PF,  15'h0A00,0,0,0};
        vt[17] = '{0,1,1,SRC_PF,  15'h0A00,1,0,0};

        reset = 1'b0; line_start = 1'b0; VBLANK_b = 1'b1;
        pf_en = 1'b1; mo_en = 1'b1; al_en = 1'b1;
        pf_addr = 15'h0A00; mo_addr = 15'h0B00; al_addr = 15'h0C00;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; stat_clr = 1'b0;
        #2 reset = 1'b1;
        tick(); tick();
        check("rst_src", vram_src, SRC_NONE);
        check("rst_we", vram_we, 0);
        check("rst_addr", vram_addr, 0);
        check("rst_ack", cpu_ack, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_wait_max", wait_max, 0);
        check("rst_valids", {pf_valid, mo_valid, al_valid}, 0);

        reset = 1'b0;
        pf_en = 1'b0; mo_en = 1'b0; al_en = 1'b0;
        line_start = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            line_start = vt[i].ls; VBLANK_b = vt[i].vb;
            pf_en = vt[i].en; mo_en = vt[i].en; al_en = vt[i].en;
            #1;
            check($sformatf("vec%0d_src", i), vram_src, vt[i].src);
            check($sformatf("vec%0d_addr", i), vram_addr, vt[i].addr);
            check($sformatf("vec%0d_valid", i), {pf_valid, mo_valid, al_valid},
                  {vt[i].pfv, vt[i].mov, vt[i].alv});
            check($sformatf("vec%0d_we_ack", i), {vram_we, cpu_ack}, 0);
            tick();
        end
        line_start = 1'b0;

        // CPU read raised in slot 1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        tick(); #1;
        check("rd_slot2_src", vram_src, SRC_MO);
        tick(); #1;
        check("rd_slot3_src", vram_src, SRC_CPU);
        check("rd_slot3_addr", vram_addr, 15'h1234);
        check("rd_slot3_ack", cpu_ack, 0);
        tick(); #1;
        check("rd_slot4_ack", cpu_ack, 1);
        check("rd_slot4_rdata", cpu_rdata, 16'hBEEF);
        tick(); #1;
        check("rd_slot5_ack", cpu_ack, 1);
        check("rd_slot5_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 1'b0;
        tick(); #1;
        check("rd_ack_drop", cpu_ack, 0);
        check("rd_wait_max", wait_max, 1);
        check("rd_rdata_hold", cpu_rdata, 16'hBEEF);

        // CPU write with AL disabled, raised in slot 3
        al_en = 1'b0; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 16'h5A5A;
        go_slot(3);
        cpu_req = 1'b1;
        tick();
        nwe = 0; we_at = -1; we_addr = '0; we_data = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (vram_we) begin
                nwe++; we_at = i; we_addr = vram_addr; we_data = vram_wdata;
            end
            if (cpu_ack) cpu_req = 1'b0;
            tick();
        end
        check("wr_count", nwe, 1);
        check("wr_slot", we_at, 0);
        check("wr_addr", we_addr, 15'h0010);
        check("wr_data", we_data, 16'h5A5A);
        check("wr_wait_max", wait_max, 1);
        al_en = 1'b1;

        // vertical blank: back-to-back reads
        VBLANK_b = 1'b0; cpu_we = 1'b0;
        for (int r = 0; r < 2; r++) begin
            cpu_addr = 15'h0020 + 15'(r);
            cpu_req = 1'b1;
            tick(); #1;
            check($sformatf("vb%0d_src", r), vram_src, SRC_CPU);
            check($sformatf("vb%0d_addr", r), vram_addr, 15'h0020 + 15'(r));
            check($sformatf("vb%0d_valid_a", r), {pf_valid, mo_valid, al_valid}, 0);
            tick(); #1;
            check($sformatf("vb%0d_ack", r), cpu_ack, 1);
            check($sformatf("vb%0d_rdata", r), cpu_rdata, 16'h0020 + 16'(r));
            check($sformatf("vb%0d_valid_b", r), {pf_valid, mo_valid, al_valid}, 0);
            cpu_req = 1'b0;
            tick(); #1;
            check($sformatf("vb%0d_ack_drop", r), cpu_ack, 0);
        end

        // reset during a pending write kills the strobe at once
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0030; cpu_wdata = 16'h1111;
        tick(); #1;
        check("rstw_pre_we", vram_we, 1);
        reset = 1'b1;
        #1;
        check("rstw_we", vram_we, 0);
        check("rstw_src", vram_src, SRC_NONE);
        cpu_req = 1'b0; cpu_we = 1'b0;
        reset = 1'b0;
        VBLANK_b = 1'b1;
        tick();

        // a raise of wait_max coinciding with stat_clr loses to the clear
        cpu_addr = 15'h1234;
        go_slot(1);
        cpu_req = 1'b1;
        tick(); tick();
        stat_clr = 1'b1;
        #1;
        check("clr_access_src", vram_src, SRC_CPU);
        tick();
        stat_clr = 1'b0;
        #1;
        check("clr_wait_max", wait_max, 0);
        check("clr_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        tick();

        // line_start at slot 5 together with a new request
        cpu_addr = 15'h0100;
        go_slot(5);
        line_start = 1'b1; cpu_req = 1'b1;
        tick();
        line_start = 1'b0;
        #1;
        check("ls_slot0_src", vram_src, SRC_PF);
        check("ls_slot0_ack", cpu_ack, 0);
        tick(); #1;
        check("ls_slot1_src", vram_src, SRC_CPU);
        check("ls_slot1_addr", vram_addr, 15'h0100);
        tick(); #1;
        check("ls_ack", cpu_ack, 1);
        check("ls_wait_max", wait_max, 1);
        check("ls_rdata", cpu_rdata, 16'h0100);
        tick(); #1;
        check("ls_slot3_ack", cpu_ack, 1);
        check("ls_slot3_mov", mo_valid, 1);

        // reset while in ACK
        reset = 1'b1;
        #1;
        check("rsta_ack", cpu_ack, 0);
        check("rsta_we", vram_we, 0);
        check("rsta_valids", {pf_valid, mo_valid, al_valid}, 0);
        check("rsta_wait_max", wait_max, 0);
        cpu_req = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_src", vram_src, SRC_PF);
        check("post_rst_addr", vram_addr, 15'h0A00);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        check("post_rst_wait_max", wait_max, 0);
        check("post_rst_slot1_src", vram_src, SRC_NONE);
        check("post_rst_pfv", pf_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Time-slot arbiter that shares the single video RAM port between the 68k CPU and three video fetch engines: playfield (PF), motion object (MO) and alphanumerics (AL).
- Runs on CLK_1H, aligned to each scan line by a line-start pulse from the sync generator.
- Video engines get fixed slots; the CPU gets odd slots, unused video slots and every slot during vertical blank.
- Drives the VRAM address/write controls and returns a DTACK-style acknowledge to the CPU bus interface.

Parameters:
- ADDR_W, 15, VRAM word-address width.
- DATA_W, 16, VRAM data width.
- WAITCNT_W, 8, width of the saturating wait-statistics counters.

Ports:
- reset  in  1  asynchronous, active-high.
- CLK_1H  in  1  clock; all state on rising edge.
- line_start  in  1  one-cycle pulse at start of each scan line.
- VBLANK_b  in  1  low during vertical blank.
- pf_en, mo_en, al_en  in  1 each  engine wants its slots this line.
- pf_addr, mo_addr, al_addr  in  ADDR_W each  engine fetch addresses.
- pf_valid, mo_valid, al_valid  out  1 each  fetch data valid on vram_rdata this cycle.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  registered CPU read data.
- cpu_ack  out  1  access complete; held until cpu_req falls.
- vram_addr  out  ADDR_W  VRAM address for the current cycle.
- vram_we  out  1  VRAM write strobe.
- vram_wdata  out  DATA_W  VRAM write data.
- vram_rdata  in  DATA_W  synchronous VRAM read data, valid the cycle after its address.
- vram_src  out  3  owner of the current cycle (slot_src_t).
- stat_clr  in  1  clears wait_max.
- wait_max  out  WAITCNT_W  longest CPU wait observed, in cycles.

Behaviour:
- Reset (async): slot_cnt=0, FSM=IDLE. cpu_ack=0, cpu_rdata=0, all *_valid=0, wait_cnt=0, wait_max=0.
- Reset values of combinational outputs: vram_we=0, vram_src=SRC_NONE, vram_addr=0.
- slot_cnt (3 bits): next value is 0 if line_start, else slot_cnt+1 mod 8. line_start wins over the increment.
- Owner decode (combinational from slot_cnt) while VBLANK_b=1:
  - slot 0: PF if pf_en.
  - slots 2 and 6: MO if mo_en.
  - slot 4: AL if al_en.
  - all odd slots, and any even slot whose engine is disabled: CPU.
- Owner decode while VBLANK_b=0: every slot is CPU.
- vram_addr, vram_we, vram_wdata, vram_src are combinational from the owner:
  - Video owner: that engine's address, we=0.
  - CPU owner with FSM=WAIT: cpu_addr, we=cpu_we, wdata=cpu_wdata, src=SRC_CPU.
  - CPU owner with no pending access: src=SRC_NONE, addr=0, we=0.
- x_valid is registered: high in the cycle after that engine owned the port, coinciding with its data on vram_rdata.
- CPU FSM:
  - IDLE -> WAIT on cpu_req.
  - WAIT: the first cycle with owner=CPU is the access. Next edge: -> ACK, and cpu_rdata <= vram_rdata on reads (unchanged on writes).
  - ACK: cpu_ack=1. Leave for IDLE when cpu_req=0.
- Minimum latency req-sampled -> ack is 2 cycles. During active display the access is guaranteed within 2 cycles of entering WAIT.
- cpu_req dropping in WAIT (protocol violation): FSM returns to IDLE and no access is made.
- wait_cnt:
  - Cleared on entering WAIT; increments each cycle in WAIT without an access; saturates at all-ones.
  - On the access, wait_max <= max(wait_max, wait_cnt).
  - stat_clr sets wait_max=0. If stat_clr and an update coincide, stat_clr wins.
- Reset during WAIT or ACK aborts the access and drops cpu_ack immediately. No VRAM write occurs after reset is asserted.
- VBLANK_b edges take effect in the same cycle's owner decode. A pending CPU access may use the first blanking slot.

Decomposition:
- Package gfx_arb_pkg:
  - slot_src_t enum {SRC_NONE, SRC_CPU, SRC_PF, SRC_MO, SRC_AL}.
  - cpu_state_t {IDLE, WAIT, ACK}.
  - Slot constants PF_SLOT=0, MO_SLOT0=2, AL_SLOT=4, MO_SLOT1=6.
- Sub-module vram_slot_decode: purely combinational (slot_cnt, VBLANK_b, *_en) -> slot_src_t. Holds the slot table in one place.

Test Plan:
- Reset, then line_start; pf/mo/al_en=1, VBLANK_b=1, no cpu_req.
  - vram_src sequence over 8 cycles is PF,NONE,MO,NONE,AL,NONE,MO,NONE.
  - pf_valid high exactly at slot 1, mo_valid at slots 3 and 7, al_valid at slot 5.
- CPU read at cpu_addr=0x1234, cpu_req raised in slot 1 so it is sampled in slot 2, VRAM model returns 0xBEEF.
  - Access occurs in slot 3.
  - cpu_ack rises in slot 4 with cpu_rdata=0xBEEF and holds until cpu_req falls.
- CPU write 0x5A5A to 0x0010 with al_en=0.
  - Access at slot 4 or the next free CPU cycle.
  - vram_we high for exactly 1 cycle with addr 0x0010 and wdata 0x5A5A; no write in PF/MO slots.
- VBLANK_b=0 with all engines enabled: all 8 slots report CPU/NONE and no *_valid pulses. Back-to-back CPU requests are each acked 2 cycles after sampling.
- line_start asserted at slot 5 while the CPU is in WAIT: slot_cnt goes to 0 next cycle. The CPU is served at slot 1, and wait_max ends at 1.
- Assert reset while in ACK: cpu_ack, vram_we and *_valid go to 0 asynchronously. After release, vram_src restarts at slot 0, and stat_clr forces wait_max to 0.
